// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: two requester ports, the shared slave bus and the arbiter status outputs.
// Latency: none, this is wiring only.
// Backpressure: each requester holds req until it sees its one-cycle ack.
interface dbus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // core memory stage (m0)
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  // secondary master (m1)
  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  // slave side
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_re;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_rdata;

  // status
  logic                  owner;
  logic                  busy;
  logic                  core_stall;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output bus_addr, bus_wdata, bus_re, bus_we,
    input  bus_rdata,
    output owner, busy, core_stall
  );

  // Environment view: requesters plus the memory/UART slave.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  bus_addr, bus_wdata, bus_re, bus_we,
    output bus_rdata,
    input  owner, busy, core_stall
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data bus between core (m0) and DMA/debug (m1); round-robin, or core priority with DBUS_ARB_CORE_PRIO_EN.
// Latency: req in cycle N -> ack in cycle N+WAIT_CYCLES+2; one transaction every WAIT_CYCLES+3 cycles.
// Backpressure: requests are held until ack; the losing master waits in order and core_stall covers a pending m0.
module dbus_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic    clk,
  input  logic    reset,
  dbus_arbiter_if.slave dbus
);

  // The wait counter is 4 bits wide; larger values cannot be represented.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
    $error("dbus_arbiter: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  last_grant;
  logic                  cur_we;

  logic                  owner_q;
  logic                  busy_q;
  logic                  bus_re_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;

  logic                  grant_vld;
  logic                  sel;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  do_grant;
  logic                  last_access;

  // Pick the winner among current requests and mux its command fields.
  always_comb begin
    grant_vld = dbus.m0_req | dbus.m1_req;
    if (dbus.m0_req & dbus.m1_req) begin
`ifdef DBUS_ARB_CORE_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant;
`endif
    end else begin
      sel = dbus.m1_req;
    end
    we_sel    = sel ? dbus.m1_we    : dbus.m0_we;
    addr_sel  = sel ? dbus.m1_addr  : dbus.m0_addr;
    wdata_sel = sel ? dbus.m1_wdata : dbus.m0_wdata;
    do_grant    = (state == S_IDLE) & grant_vld;
    last_access = (state == S_ACCESS) & (cnt == 4'd0);
  end

  // Sequencer: IDLE -> ACCESS for WAIT_CYCLES+1 cycles -> RESP for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_grant) begin
            state <= S_ACCESS;
            cnt   <= WAIT_INIT;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch the winner's command at grant; later changes by the requester are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= 1'b0;
      last_grant  <= 1'b1;
      cur_we      <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else if (do_grant) begin
      owner_q     <= sel;
      last_grant  <= sel;
      cur_we      <= we_sel;
      bus_addr_q  <= addr_sel;
      bus_wdata_q <= wdata_sel;
    end
  end

  // Slave strobes: read enable for the whole access, write strobe only on its final cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_re_q <= 1'b0;
      bus_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (do_grant) begin
      bus_re_q <= ~we_sel;
      bus_we_q <= we_sel & (WAIT_INIT == 4'd0);
      busy_q   <= 1'b1;
    end else if (state == S_ACCESS) begin
      if (cnt == 4'd0) begin
        bus_re_q <= 1'b0;
        bus_we_q <= 1'b0;
      end else begin
        bus_we_q <= cur_we & (cnt == 4'd1);
      end
    end else if (state == S_RESP) begin
      busy_q <= 1'b0;
    end
  end

  // One-cycle ack to the owner only, asserted during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
    end else begin
      m0_ack_q <= last_access & ~owner_q;
      m1_ack_q <= last_access &  owner_q;
    end
  end

  // Capture slave read data into the owner's register on the last access cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (last_access & ~cur_we) begin
      if (owner_q) begin
        m1_rdata_q <= dbus.bus_rdata;
      end else begin
        m0_rdata_q <= dbus.bus_rdata;
      end
    end
  end

  assign dbus.m0_ack     = m0_ack_q;
  assign dbus.m1_ack     = m1_ack_q;
  assign dbus.m0_rdata   = m0_rdata_q;
  assign dbus.m1_rdata   = m1_rdata_q;
  assign dbus.bus_addr   = bus_addr_q;
  assign dbus.bus_wdata  = bus_wdata_q;
  assign dbus.bus_re     = bus_re_q;
  assign dbus.bus_we     = bus_we_q;
  assign dbus.owner      = owner_q;
  assign dbus.busy       = busy_q;
  assign dbus.core_stall = dbus.m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: random two-master traffic on three arbiters (WAIT_CYCLES 0, 2, 5) against a timeline model.
// Latency: model places grant at cycle g, access g+1..g+W+1, ack g+W+2, next arbitration g+W+3.
// Backpressure: model requesters hold req until ack, may drop or scramble fields after grant.
module tb_dbus_arbiter;

  bit clk;
  int checks;
  int errors;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int W = (k == 0) ? 0 : ((k == 1) ? 2 : 5);

    logic rst;
    bit   done;

    dbus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif ();

    dbus_arbiter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .WAIT_CYCLES(W)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .dbus (bif)
    );

    initial begin : run
      int          cyc, g, a, hot;
      bit          have_tx, acc, rsp, idle, did_rst, sel, last;
      bit          t_own, t_we, e_own;
      logic [31:0] t_addr, t_wdata, t_rd, e_baddr, e_bwdata, rd_now;
      logic [31:0] e_rd [2];
      bit          pend [2];
      bit          granted [2];
      bit          mwe [2];
      logic [31:0] maddr [2];
      logic [31:0] mwd [2];
      string       p;

      p = $sformatf("w%0d", W);
      have_tx = 0; did_rst = 0; last = 1; g = 0; cyc = 0;
      t_own = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_rd = 0;
      e_own = 0; e_baddr = 0; e_bwdata = 0; e_rd[0] = 0; e_rd[1] = 0;
      for (int i = 0; i < 2; i++) begin
        pend[i] = 0; granted[i] = 0; mwe[i] = 0; maddr[i] = 0; mwd[i] = 0;
      end
      bif.m0_req = 0; bif.m0_we = 0; bif.m0_addr = 0; bif.m0_wdata = 0;
      bif.m1_req = 0; bif.m1_we = 0; bif.m1_addr = 0; bif.m1_wdata = 0;
      bif.bus_rdata = 0;
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      check({p, "_rst_busy"},   bif.busy, 0);
      check({p, "_rst_re"},     bif.bus_re, 0);
      check({p, "_rst_we"},     bif.bus_we, 0);
      check({p, "_rst_m0ack"},  bif.m0_ack, 0);
      check({p, "_rst_m1ack"},  bif.m1_ack, 0);
      check({p, "_rst_owner"},  bif.owner, 0);
      check({p, "_rst_m0rd"},   bif.m0_rdata, 0);
      check({p, "_rst_m1rd"},   bif.m1_rdata, 0);
      check({p, "_rst_addr"},   bif.bus_addr, 0);
      check({p, "_rst_wdata"},  bif.bus_wdata, 0);
      check({p, "_rst_stall"},  bif.core_stall, 0);
      rst = 0;

      for (int n = 0; n < 1500; n++) begin
        @(negedge clk);
        cyc++;
        a    = have_tx ? (cyc - g) : 0;
        acc  = have_tx && (a >= 1) && (a <= W + 1);
        rsp  = have_tx && (a == W + 2);
        idle = !have_tx || (a >= W + 3);

        // Asynchronous reset between edges, in the middle of an access.
        if (!did_rst && n >= 700 && acc && a == ((W >= 1) ? 2 : 1)) begin
          #2 rst = 1;
          #1;
          check({p, "_arst_busy"},  bif.busy, 0);
          check({p, "_arst_re"},    bif.bus_re, 0);
          check({p, "_arst_we"},    bif.bus_we, 0);
          check({p, "_arst_m0ack"}, bif.m0_ack, 0);
          check({p, "_arst_m1ack"}, bif.m1_ack, 0);
          check({p, "_arst_owner"}, bif.owner, 0);
          have_tx = 0; last = 1; e_own = 0; e_baddr = 0; e_bwdata = 0;
          e_rd[0] = 0; e_rd[1] = 0;
          for (int i = 0; i < 2; i++) begin
            pend[i] = 0; granted[i] = 0;
          end
          bif.m0_req = 0;
          bif.m1_req = 0;
          @(negedge clk);
          cyc++;
          rst = 0;
          did_rst = 1;
          continue;
        end

        if (rsp && !t_we) e_rd[t_own] = t_rd;

        check({p, "_busy"},   bif.busy, acc || rsp);
        check({p, "_bus_re"}, bif.bus_re, acc && !t_we);
        check({p, "_bus_we"}, bif.bus_we, acc && t_we && (a == W + 1));
        check({p, "_m0_ack"}, bif.m0_ack, rsp && !t_own);
        check({p, "_m1_ack"}, bif.m1_ack, rsp && t_own);
        check({p, "_m0_rd"},  bif.m0_rdata, e_rd[0]);
        check({p, "_m1_rd"},  bif.m1_rdata, e_rd[1]);
        check({p, "_owner"},  bif.owner, e_own);
        check({p, "_addr"},   bif.bus_addr, e_baddr);
        check({p, "_wdata"},  bif.bus_wdata, e_bwdata);

        // Requesters: alternate between light traffic and saturating contention.
        hot = (((n / 250) % 2) == 1) ? 100 : 30;
        for (int i = 0; i < 2; i++) begin
          if (rsp && (i == int'(t_own))) begin
            granted[i] = 0;
            pend[i]    = 0;
          end
          if (granted[i] && pend[i] && acc && ($urandom_range(5) == 0)) pend[i] = 0;
          if (granted[i] && pend[i]) begin
            maddr[i] = $urandom; mwd[i] = $urandom; mwe[i] = 1'($urandom_range(1));
          end
          if (!granted[i] && !pend[i] && ($urandom_range(99) < hot)) begin
            pend[i] = 1; maddr[i] = $urandom; mwd[i] = $urandom; mwe[i] = 1'($urandom_range(1));
          end
        end
        bif.m0_req = pend[0]; bif.m0_we = mwe[0]; bif.m0_addr = maddr[0]; bif.m0_wdata = mwd[0];
        bif.m1_req = pend[1]; bif.m1_we = mwe[1]; bif.m1_addr = maddr[1]; bif.m1_wdata = mwd[1];
        rd_now = $urandom;
        bif.bus_rdata = rd_now;
        if (acc && (a == W + 1)) t_rd = rd_now;

        #1;
        check({p, "_stall"}, bif.core_stall, pend[0] && !(rsp && !t_own));

        // Arbitration happens only on an idle cycle, using requests seen this cycle.
        if (idle && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) begin
`ifdef DBUS_ARB_CORE_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last;
`endif
          end else begin
            sel = pend[1];
          end
          have_tx = 1; g = cyc; t_own = sel;
          t_we = mwe[sel]; t_addr = maddr[sel]; t_wdata = mwd[sel];
          last = sel; granted[sel] = 1;
          e_own = sel; e_baddr = t_addr; e_bwdata = t_wdata;
        end
      end
      check({p, "_reset_hit"}, did_rst, 1);
      done = 1;
    end
  end

  initial begin : top
    bit all_done;
    all_done = 0;
    for (int t = 0; t < 5000 && !all_done; t++) begin
      @(negedge clk);
      #2;
      all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done;
    end
    check("all_done", all_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Sequences and shares the data-memory bus (dmem/UART via LSU decode) between two requesters: m0 = core memory stage, m1 = secondary master (DMA/debug loader).
- Round-robin arbitration, programmable wait states, one-cycle ack/response per transaction.
- Produces a core stall while the core's access is pending.
- Sits between the core's memory stage and the LSU/dmem/uart slave side.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- WAIT_CYCLES, 0, extra slave wait states per access (0..15); counter width 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  core request; held high until m0_ack.
- m0_we  in  1  core write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  core address.
- m0_wdata  in  DATA_WIDTH  core write data.
- m0_ack  out  1  one-cycle completion pulse to core.
- m0_rdata  out  DATA_WIDTH  read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as the m0 ports, for the secondary master.
- bus_addr  out  ADDR_WIDTH  slave address (latched).
- bus_wdata  out  DATA_WIDTH  slave write data (latched).
- bus_re  out  1  slave read enable.
- bus_we  out  1  slave write strobe.
- bus_rdata  in  DATA_WIDTH  slave read data (combinational from slave).
- owner  out  1  current/last granted master (0=m0, 1=m1).
- busy  out  1  state != IDLE.
- core_stall  out  1  combinational: m0_req & ~m0_ack.

Behaviour:
- Reset (async, immediate): state=IDLE; wait counter=0; last_grant=1, so m0 wins the first tie. All registered outputs are 0: acks, rdata, bus_*, owner, busy.
- Reset mid-transaction aborts it. A bus_we already issued is not undone; no ack is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample requests each cycle.
  - One requester: grant it.
  - Both requesting: grant the master != last_grant.
  - On grant at edge N: latch addr, wdata, we and owner; set last_grant=owner; cnt=WAIT_CYCLES; go to ACCESS.
- ACCESS: lasts WAIT_CYCLES+1 cycles.
  - bus_addr/bus_wdata stable throughout.
  - Reads: bus_re=1 every ACCESS cycle.
  - Writes: bus_we=1 only on the final ACCESS cycle (cnt==0), exactly one cycle per write.
  - cnt decrements each cycle.
  - At cnt==0: capture bus_rdata into the owner's rdata register (reads only) and go to RESP.
- RESP: the owner's ack=1 for exactly one cycle, with rdata valid (writes: ack only, rdata unchanged). Next state is IDLE.
- Latency: req high in cycle N gives ack in cycle N+WAIT_CYCLES+2. Back-to-back throughput is one transaction per WAIT_CYCLES+3 cycles.
- The non-owner's ack is always 0; its request waits (no drop, no reorder).
- Requester rules:
  - Changing addr/we/wdata after grant has no effect.
  - Dropping req during ACCESS/RESP does not cancel; the transaction completes and acks.
  - req still high in the cycle after ack is a new transaction.
- Simultaneous requests arriving while busy are arbitrated in IDLE after RESP, using the updated last_grant, so alternation is guaranteed under continuous contention.
- WAIT_CYCLES values above 15 are a parameter error.

Optional Feature:
- Macro DBUS_ARB_CORE_PRIO_EN.
- Defined: fixed priority. m0 always wins a tie in IDLE; last_grant is still tracked and output via owner, but is ignored for selection. m1 can starve.
- Undefined: round-robin as described above.

Test Plan:
- Single core read, WAIT_CYCLES=0: m0_req=1, we=0, addr=0x10, bus_rdata=0xDEADBEEF. Required: bus_re high in cycle 1; m0_ack and m0_rdata=0xDEADBEEF in cycle 2; core_stall high in cycles 0-1 and low in cycle 2.
- Core write, WAIT_CYCLES=3: m0 writes 0xA5A5A5A5 to 0x20. Required: bus_addr=0x20 and bus_wdata=0xA5A5A5A5 for 4 ACCESS cycles; bus_we high only in the 4th; m0_ack in cycle 5; bus_re never high.
- Contention: m0 and m1 both hold req for 4 transactions each. Required: grants alternate m0, m1, m0, m1…, with m0 first after reset; each ack at the expected WAIT_CYCLES+3 spacing. With DBUS_ARB_CORE_PRIO_EN, all m0 transactions complete before any m1.
- Request drop: m1 read granted, m1_req deasserted mid-ACCESS (WAIT_CYCLES=2). Required: transaction completes; m1_ack pulses once; state returns to IDLE; no second access.
- Async reset mid-ACCESS (WAIT_CYCLES=5, cycle 2): assert reset between clock edges. Required: busy, bus_re, bus_we, acks and owner go to 0 immediately; no ack after release; the next m0 request is served normally.
- Ack isolation: m1 write while m0 idle. Required: m0_ack stays 0 throughout; m0_rdata is unchanged from its prior value; owner=1 from grant onward.
